// File: rtl/dma_pkg.sv
// Shared DMA types: descriptor layout, sequencer state encoding and descriptor index helpers.
package dma_pkg;

    localparam int DMA_MAX_NUM_DESC = 8;
    localparam int DMA_DESC_IDX_W   = $clog2(DMA_MAX_NUM_DESC + 1);

    typedef logic [DMA_DESC_IDX_W-1:0] dma_desc_idx_t;

    typedef struct packed {
        logic [31:0] src_addr;
        logic [31:0] dst_addr;
        logic [31:0] num_bytes;
    } s_dma_desc_t;

    typedef enum logic [2:0] {
        DMA_ST_IDLE,
        DMA_ST_CFG,
        DMA_ST_RUN,
        DMA_ST_DRAIN,
        DMA_ST_DONE
    } dma_fsm_st_t;

    // Advance a slot index, parking it on num_desc once the table is exhausted
    function automatic dma_desc_idx_t dma_idx_inc(input dma_desc_idx_t idx, input int num_desc);
        if (int'(idx) >= num_desc) begin
            return idx;
        end
        return idx + dma_desc_idx_t'(1);
    endfunction

endpackage

// File: rtl/dma_fsm.sv
// DMA sequencer: walks the CSR descriptor table and starts the read/write streamers per slot.
// Optional per-descriptor watchdog is enabled by defining DMA_FSM_WATCHDOG_EN.
module dma_fsm
    import dma_pkg::*;
#(
    parameter int DMA_NUM_DESC    = 2,
    parameter int DMA_WDOG_CYCLES = 65536,
    localparam int IDX_W          = $clog2(DMA_NUM_DESC + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    dma_go_i,
    input  logic                    dma_abort_i,
    input  s_dma_desc_t             dma_desc_i [DMA_NUM_DESC],
    input  logic [DMA_NUM_DESC-1:0] dma_desc_en_i,
    output s_dma_desc_t             dma_desc_o,
    output logic                    dma_rd_stream_valid_o,
    output logic                    dma_wr_stream_valid_o,
    input  logic                    dma_rd_stream_done_i,
    input  logic                    dma_wr_stream_done_i,
    input  logic                    dma_axi_pend_i,
    input  logic                    dma_axi_err_i,
    output logic                    dma_active_o,
    output logic                    dma_done_o,
    output logic                    dma_error_o,
    output logic                    dma_abort_o,
    output logic [IDX_W-1:0]        dma_desc_idx_o
);

    if (DMA_NUM_DESC < 1 || DMA_NUM_DESC > DMA_MAX_NUM_DESC || DMA_WDOG_CYCLES < 1) begin : g_bad_param
        $error("dma_fsm: DMA_NUM_DESC must be 1..8 and DMA_WDOG_CYCLES at least 1");
    end

    dma_fsm_st_t   state, state_nxt;
    dma_desc_idx_t idx, idx_nxt;
    s_dma_desc_t   desc_q, desc_nxt;
    s_dma_desc_t   cur_desc;
    logic          cur_en;
    logic          run_first, run_first_nxt;
    logic          rd_seen, rd_seen_nxt, rd_seen_now;
    logic          wr_seen, wr_seen_nxt, wr_seen_now;
    logic          abort_pend, abort_pend_nxt;
    logic          error_q, error_nxt;
    logic          abort_q, abort_nxt;

`ifdef DMA_FSM_WATCHDOG_EN
    localparam logic [31:0] WDOG_LIMIT = 32'(DMA_WDOG_CYCLES);
    logic [31:0] wdog_cnt, wdog_nxt;
`endif

    // Slot selected by the current index; out-of-range reads as a disabled empty slot
    always_comb begin
        cur_desc = '0;
        cur_en   = 1'b0;
        for (int i = 0; i < DMA_NUM_DESC; i++) begin
            if (idx == dma_desc_idx_t'(i)) begin
                cur_desc = dma_desc_i[i];
                cur_en   = dma_desc_en_i[i];
            end
        end
    end

    assign rd_seen_now = rd_seen | dma_rd_stream_done_i;
    assign wr_seen_now = wr_seen | dma_wr_stream_done_i;

    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        desc_nxt       = desc_q;
        run_first_nxt  = 1'b0;
        rd_seen_nxt    = rd_seen;
        wr_seen_nxt    = wr_seen;
        abort_pend_nxt = abort_pend;
        error_nxt      = error_q;
        abort_nxt      = abort_q;

        // A bus error anywhere in an operation stops it at the next safe point
        if (state != DMA_ST_IDLE && dma_axi_err_i) begin
            error_nxt      = 1'b1;
            abort_pend_nxt = 1'b1;
        end

        case (state)
            DMA_ST_IDLE: begin
                if (dma_go_i) begin
                    error_nxt      = 1'b0;
                    abort_nxt      = 1'b0;
                    abort_pend_nxt = 1'b0;
                    idx_nxt        = '0;
                    rd_seen_nxt    = 1'b0;
                    wr_seen_nxt    = 1'b0;
                    state_nxt      = DMA_ST_CFG;
                end
            end
            DMA_ST_CFG: begin
                if (idx == dma_desc_idx_t'(DMA_NUM_DESC)) begin
                    state_nxt = DMA_ST_DONE;
                end else if (abort_pend || dma_abort_i) begin
                    abort_nxt = 1'b1;
                    state_nxt = DMA_ST_DONE;
                end else if (!cur_en || cur_desc.num_bytes == 32'd0) begin
                    idx_nxt = dma_idx_inc(idx, DMA_NUM_DESC);
                end else begin
                    desc_nxt      = cur_desc;
                    run_first_nxt = 1'b1;
                    state_nxt     = DMA_ST_RUN;
                end
            end
            DMA_ST_RUN: begin
                // Streamers cannot be cancelled, so an abort only waits for both dones
                if (dma_abort_i) begin
                    abort_pend_nxt = 1'b1;
                end
                rd_seen_nxt = rd_seen_now;
                wr_seen_nxt = wr_seen_now;
                if (rd_seen_now && wr_seen_now) begin
                    rd_seen_nxt = 1'b0;
                    wr_seen_nxt = 1'b0;
                    state_nxt   = DMA_ST_DRAIN;
                end
            end
            DMA_ST_DRAIN: begin
                if (dma_abort_i) begin
                    abort_pend_nxt = 1'b1;
                end
                if (!dma_axi_pend_i) begin
                    if (error_q || abort_pend) begin
                        abort_nxt = abort_pend;
                        state_nxt = DMA_ST_DONE;
                    end else begin
                        idx_nxt   = dma_idx_inc(idx, DMA_NUM_DESC);
                        state_nxt = DMA_ST_CFG;
                    end
                end
            end
            DMA_ST_DONE: begin
                state_nxt = DMA_ST_IDLE;
            end
            default: begin
                state_nxt = DMA_ST_IDLE;
            end
        endcase

`ifdef DMA_FSM_WATCHDOG_EN
        // Counter restarts with each descriptor and parks at the limit once it fires
        wdog_nxt = wdog_cnt;
        if (state == DMA_ST_CFG && state_nxt == DMA_ST_RUN) begin
            wdog_nxt = '0;
        end else if (state == DMA_ST_RUN || state == DMA_ST_DRAIN) begin
            wdog_nxt = wdog_cnt + 32'd1;
            if (wdog_nxt >= WDOG_LIMIT) begin
                error_nxt   = 1'b1;
                rd_seen_nxt = 1'b0;
                wr_seen_nxt = 1'b0;
                state_nxt   = DMA_ST_DONE;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= DMA_ST_IDLE;
            idx        <= '0;
            desc_q     <= '0;
            run_first  <= 1'b0;
            rd_seen    <= 1'b0;
            wr_seen    <= 1'b0;
            abort_pend <= 1'b0;
            error_q    <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            desc_q     <= desc_nxt;
            run_first  <= run_first_nxt;
            rd_seen    <= rd_seen_nxt;
            wr_seen    <= wr_seen_nxt;
            abort_pend <= abort_pend_nxt;
            error_q    <= error_nxt;
            abort_q    <= abort_nxt;
        end
    end

`ifdef DMA_FSM_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
        end else begin
            wdog_cnt <= wdog_nxt;
        end
    end
`endif

    assign dma_desc_o            = desc_q;
    assign dma_rd_stream_valid_o = (state == DMA_ST_RUN) && run_first;
    assign dma_wr_stream_valid_o = (state == DMA_ST_RUN) && run_first;
    assign dma_active_o          = (state != DMA_ST_IDLE);
    assign dma_done_o            = (state == DMA_ST_DONE);
    assign dma_error_o           = error_q;
    assign dma_abort_o           = abort_q;
    assign dma_desc_idx_o        = idx[IDX_W-1:0];

endmodule

// File: tb/tb_dma_fsm.sv
// Directed bench for dma_fsm: a per-scenario timeline model predicts every output cycle by cycle.
module tb_dma_fsm;
    import dma_pkg::*;

    localparam int NDESC = 2;
    localparam int WDOG  = 16;
    localparam int MAXC  = 80;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              dma_go_i, dma_abort_i;
    s_dma_desc_t       dma_desc_i [NDESC];
    logic [NDESC-1:0]  dma_desc_en_i;
    s_dma_desc_t       dma_desc_o;
    logic              dma_rd_stream_valid_o, dma_wr_stream_valid_o;
    logic              dma_rd_stream_done_i, dma_wr_stream_done_i;
    logic              dma_axi_pend_i, dma_axi_err_i;
    logic              dma_active_o, dma_done_o, dma_error_o, dma_abort_o;
    logic [1:0]        dma_desc_idx_o;

    dma_fsm #(.DMA_NUM_DESC(NDESC), .DMA_WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .rst_n(rst_n), .dma_go_i(dma_go_i), .dma_abort_i(dma_abort_i),
        .dma_desc_i(dma_desc_i), .dma_desc_en_i(dma_desc_en_i), .dma_desc_o(dma_desc_o),
        .dma_rd_stream_valid_o(dma_rd_stream_valid_o), .dma_wr_stream_valid_o(dma_wr_stream_valid_o),
        .dma_rd_stream_done_i(dma_rd_stream_done_i), .dma_wr_stream_done_i(dma_wr_stream_done_i),
        .dma_axi_pend_i(dma_axi_pend_i), .dma_axi_err_i(dma_axi_err_i),
        .dma_active_o(dma_active_o), .dma_done_o(dma_done_o), .dma_error_o(dma_error_o),
        .dma_abort_o(dma_abort_o), .dma_desc_idx_o(dma_desc_idx_o)
    );

    always #5 clk = ~clk;

    logic        st_go [MAXC], st_abort [MAXC], st_rd [MAXC], st_wr [MAXC], st_pend [MAXC], st_err [MAXC];
    logic        exp_valid [MAXC], exp_active [MAXC], exp_done [MAXC], exp_error [MAXC], exp_abort [MAXC];
    int          exp_idx [MAXC];
    s_dma_desc_t exp_desc [MAXC];

    int          scen_len, cyc, checks, errors, done_at;
    int          valid_q [$];
    logic        chk_en;
    logic        prev_error, prev_abort;
    int          prev_idx;
    s_dma_desc_t prev_desc;

    task automatic check_output(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic set_table(input logic en0, input int bytes0, input logic en1, input int bytes1);
        dma_desc_en_i = {en1, en0};
        dma_desc_i[0] = '{src_addr: 32'h1000_0000, dst_addr: 32'h2000_0000, num_bytes: 32'(bytes0)};
        dma_desc_i[1] = '{src_addr: 32'h1000_4000, dst_addr: 32'h2000_8000, num_bytes: 32'(bytes1)};
    endtask

    // Lay out the whole operation on a cycle timeline: cycle 0 is the go cycle
    task automatic build(input int rd_lat, input int wr_lat, input int pend_len,
                         input int abort_cyc, input int err_cyc, input int extra_go, input bit hang);
        int          t, slot, run_s, run_e, d_end, done_c, err_from;
        bit          ab_end;
        s_dma_desc_t cur;
        for (int c = 0; c < MAXC; c++) begin
            st_go[c] = 0; st_abort[c] = 0; st_rd[c] = 0; st_wr[c] = 0; st_pend[c] = 0; st_err[c] = 0;
            exp_valid[c] = 0; exp_active[c] = 0; exp_done[c] = 0; exp_error[c] = 0; exp_abort[c] = 0;
            exp_idx[c] = 0; exp_desc[c] = '0;
        end
        st_go[0] = 1;
        if (extra_go >= 0) st_go[extra_go] = 1;
        if (abort_cyc >= 0) st_abort[abort_cyc] = 1;
        if (err_cyc >= 0) st_err[err_cyc] = 1;
        cur = prev_desc; slot = 0; t = 1; done_c = -1; err_from = -1; ab_end = 0;
        exp_idx[0] = prev_idx; exp_desc[0] = prev_desc;
        while (done_c < 0) begin
            exp_active[t] = 1; exp_idx[t] = slot; exp_desc[t] = cur;
            if (slot == NDESC) begin
                done_c = t + 1;
            end else if (!dma_desc_en_i[slot] || dma_desc_i[slot].num_bytes == 32'd0) begin
                slot++; t++;
            end else begin
                cur = dma_desc_i[slot]; run_s = t + 1;
                if (hang) begin
                    d_end = run_s + WDOG - 1; err_from = run_s + WDOG; done_c = run_s + WDOG;
                end else begin
                    run_e = run_s + ((rd_lat > wr_lat) ? rd_lat : wr_lat);
                    d_end = run_e + 1 + pend_len;
                    st_rd[run_s + rd_lat] = 1; st_wr[run_s + wr_lat] = 1;
                    for (int c = run_s; c <= run_e + pend_len; c++) st_pend[c] = 1;
                    if (err_cyc >= run_s && err_cyc <= run_e) err_from = err_cyc + 1;
                    if ((abort_cyc >= run_s && abort_cyc <= run_e) || err_from >= 0) begin
                        ab_end = 1; done_c = d_end + 1;
                    end else begin
                        t = d_end + 1;
                    end
                end
                for (int c = run_s; c <= d_end; c++) begin
                    exp_active[c] = 1; exp_idx[c] = slot; exp_desc[c] = cur;
                end
                exp_valid[run_s] = 1;
                if (done_c < 0) slot++;
            end
        end
        exp_active[done_c] = 1; exp_done[done_c] = 1; exp_idx[done_c] = slot; exp_desc[done_c] = cur;
        for (int c = done_c + 1; c <= done_c + 3; c++) begin
            exp_idx[c] = slot; exp_desc[c] = cur;
        end
        scen_len = done_c + 4;
        exp_error[0] = prev_error; exp_abort[0] = prev_abort;
        for (int c = 1; c < scen_len; c++) begin
            exp_error[c] = (err_from >= 0 && c >= err_from);
            exp_abort[c] = (ab_end && c >= done_c);
        end
        prev_error = exp_error[scen_len-1]; prev_abort = exp_abort[scen_len-1];
        prev_idx = slot; prev_desc = cur;
    endtask

    task automatic apply_stimulus();
        valid_q.delete();
        done_at = -1;
        for (int c = 0; c < scen_len; c++) begin
            @(posedge clk); #1;
            cyc = c; chk_en = 1'b1;
            dma_go_i = st_go[c]; dma_abort_i = st_abort[c];
            dma_rd_stream_done_i = st_rd[c]; dma_wr_stream_done_i = st_wr[c];
            dma_axi_pend_i = st_pend[c]; dma_axi_err_i = st_err[c];
        end
        @(posedge clk); #1;
        chk_en = 1'b0;
        dma_go_i = 0; dma_abort_i = 0; dma_rd_stream_done_i = 0; dma_wr_stream_done_i = 0;
        dma_axi_pend_i = 0; dma_axi_err_i = 0;
    endtask

    // Per-cycle comparison of every output against the timeline model
    always @(negedge clk) begin
        if (chk_en) begin
            check_output("active", dma_active_o, exp_active[cyc]);
            check_output("done", dma_done_o, exp_done[cyc]);
            check_output("rd_valid", dma_rd_stream_valid_o, exp_valid[cyc]);
            check_output("wr_valid", dma_wr_stream_valid_o, exp_valid[cyc]);
            check_output("error", dma_error_o, exp_error[cyc]);
            check_output("abort", dma_abort_o, exp_abort[cyc]);
            check_output("idx", dma_desc_idx_o, exp_idx[cyc]);
            check_output("desc", dma_desc_o, exp_desc[cyc]);
            if (dma_rd_stream_valid_o) valid_q.push_back(cyc);
            if (dma_done_o && done_at < 0) done_at = cyc;
        end
    end

    initial begin
        checks = 0; errors = 0; chk_en = 0; cyc = 0;
        prev_error = 0; prev_abort = 0; prev_idx = 0; prev_desc = '0;
        dma_go_i = 0; dma_abort_i = 0; dma_rd_stream_done_i = 0; dma_wr_stream_done_i = 0;
        dma_axi_pend_i = 0; dma_axi_err_i = 0;
        set_table(1, 256, 1, 256);
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_active", dma_active_o, 0);
        check_output("reset_valid", dma_rd_stream_valid_o | dma_wr_stream_valid_o, 0);
        check_output("reset_flags", {dma_done_o, dma_error_o, dma_abort_o}, 0);
        check_output("reset_idx", dma_desc_idx_o, 0);
        check_output("reset_desc", dma_desc_o, 0);
        rst_n = 1;

        $display("[TB] two descriptors, staggered dones, stray go mid-run");
        set_table(1, 256, 1, 256);
        build(5, 8, 2, -1, -1, 5, 0);
        apply_stimulus();
        check_output("s1_done_cycle", done_at, 28);
        check_output("s1_valid_count", valid_q.size(), 2);
        if (valid_q.size() == 2) begin
            check_output("s1_valid0_cycle", valid_q[0], 2);
            check_output("s1_valid1_cycle", valid_q[1], 15);
        end

        $display("[TB] disabled slot and empty slot, abort alongside go");
        set_table(0, 256, 1, 0);
        build(0, 0, 0, 0, -1, -1, 0);
        apply_stimulus();
        check_output("s2_done_cycle", done_at, 4);
        check_output("s2_valid_count", valid_q.size(), 0);

        $display("[TB] same-cycle dones, no pending traffic");
        set_table(1, 64, 1, 128);
        build(3, 3, 0, -1, -1, -1, 0);
        apply_stimulus();
        check_output("s3_valid_count", valid_q.size(), 2);
        if (valid_q.size() == 2) check_output("s3_valid1_cycle", valid_q[1], 8);
        check_output("s3_done_cycle", done_at, 14);

        $display("[TB] write done in the valid cycle, read later");
        set_table(1, 32, 1, 4096);
        build(4, 0, 1, -1, -1, -1, 0);
        apply_stimulus();

        $display("[TB] abort during first descriptor");
        set_table(1, 256, 1, 256);
        build(5, 8, 2, 4, -1, -1, 0);
        apply_stimulus();
        check_output("s5_done_cycle", done_at, 14);
        check_output("s5_valid_count", valid_q.size(), 1);

        $display("[TB] bus error during first descriptor");
        build(5, 8, 2, -1, 5, -1, 0);
        apply_stimulus();
        check_output("s6_error_idle", dma_error_o, 1);

        $display("[TB] clean run after error clears sticky flags");
        build(2, 1, 1, -1, -1, -1, 0);
        apply_stimulus();
        check_output("s7_error_cleared", dma_error_o, 0);

`ifdef DMA_FSM_WATCHDOG_EN
        $display("[TB] hung streamer trips watchdog");
        build(0, 0, 0, -1, -1, -1, 1);
        apply_stimulus();
        check_output("s8_done_cycle", done_at, 18);
`endif

        $display("[TB] asynchronous reset mid-operation");
        @(posedge clk); #1;
        dma_go_i = 1;
        @(posedge clk); #1;
        dma_go_i = 0;
        repeat (2) @(posedge clk);
        #1;
        check_output("pre_reset_active", dma_active_o, 1);
        rst_n = 0;
        #1;
        check_output("async_reset_active", dma_active_o, 0);
        check_output("async_reset_desc", dma_desc_o, 0);
        check_output("async_reset_idx", dma_desc_idx_o, 0);
        @(posedge clk); #1;
        rst_n = 1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_fsm.md
Name: dma_fsm

Overview:
- Top-level DMA sequencer. Walks a small table of CSR descriptors and presents each in turn to the read and write streamers.
- Starts both streamers together for each descriptor. Waits for both to finish and for the AXI I/F to drain outstanding transactions, then advances to the next descriptor.
- Sits between the CSR block and the read/write dma_streamer instances. Reports active/done/error/abort status back to the CSRs.

Parameters:
- DMA_NUM_DESC, 2, number of descriptor slots in the table (1..8).
- DMA_WDOG_CYCLES, 65536, watchdog limit in cycles per descriptor (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- dma_go_i  in  1  start request from CSR, level-sampled in IDLE.
- dma_abort_i  in  1  abort request from CSR, level-sampled outside IDLE.
- dma_desc_i  in  DMA_NUM_DESC x s_dma_desc_t  descriptor table.
- dma_desc_en_i  in  DMA_NUM_DESC  per-slot enable.
- dma_desc_o  out  s_dma_desc_t  current descriptor to both streamers.
- dma_rd_stream_valid_o  out  1  start pulse to the read streamer.
- dma_wr_stream_valid_o  out  1  start pulse to the write streamer.
- dma_rd_stream_done_i  in  1  done pulse from the read streamer.
- dma_wr_stream_done_i  in  1  done pulse from the write streamer.
- dma_axi_pend_i  in  1  AXI I/F has outstanding AR/AW/W/B/R traffic.
- dma_axi_err_i  in  1  SLVERR/DECERR seen on RRESP/BRESP (one-cycle pulse).
- dma_active_o  out  1  high in any state other than IDLE.
- dma_done_o  out  1  one-cycle pulse at end of operation.
- dma_error_o  out  1  sticky error flag.
- dma_abort_o  out  1  sticky flag: operation ended by abort.
- dma_desc_idx_o  out  $clog2(DMA_NUM_DESC+1)  index of the current slot.

Behaviour:
- Reset (async, rst_n=0): state IDLE, and every output and internal flag is 0, including dma_desc_o.
- States: DMA_ST_IDLE, DMA_ST_CFG, DMA_ST_RUN, DMA_ST_DRAIN, DMA_ST_DONE.
- IDLE:
  - dma_go_i=1 -> clear error, abort, idx and done-seen flags; go to CFG next cycle.
  - dma_abort_i is ignored; go wins if both are high.
- CFG:
  - idx==DMA_NUM_DESC -> DONE.
  - Abort pending, or dma_abort_i=1 -> set abort flag and go to DONE.
  - Slot disabled, or num_bytes==0 -> idx+1 and stay in CFG (one cycle per skipped slot).
  - Otherwise -> register dma_desc_o<=dma_desc_i[idx] and go to RUN.
- RUN:
  - In the first RUN cycle, both stream valids are high for exactly that one cycle, with dma_desc_o already stable.
  - dma_desc_o holds until the next CFG load.
  - Sticky rd_seen/wr_seen set on the respective done pulses. Pulses may arrive in any order, including the same cycle, and a done in the valid cycle itself is accepted.
  - When both seen flags are set (including a flag set this cycle) -> DRAIN, and clear both flags.
  - dma_abort_i=1 -> latch abort pending. Streamers cannot be stopped, so the FSM stays in RUN until both dones arrive.
- DRAIN: wait for dma_axi_pend_i==0.
  - Then, if error or abort is pending -> DONE, setting dma_abort_o if abort is pending.
  - Otherwise idx+1 -> CFG.
- DONE: dma_done_o=1 for one cycle -> IDLE.
- dma_axi_err_i in any non-IDLE state: set dma_error_o and abort pending. dma_error_o is cleared only by the next accepted go.
- dma_go_i outside IDLE is ignored.
- idx saturates at DMA_NUM_DESC. No wrap-around.
- Reset mid-operation returns to IDLE immediately. Streamers are reset by the same rst_n.

Optional Feature:
- DMA_FSM_WATCHDOG_EN defined:
  - A 32-bit counter clears on entry to RUN and increments in RUN/DRAIN.
  - Reaching DMA_WDOG_CYCLES sets dma_error_o and goes directly to DONE. The counter holds.
- Not defined: no counter, and a hung streamer leaves the FSM in RUN.

Decomposition:
- dma_pkg gains:
  - enum dma_fsm_st_t (5 states).
  - DMA_MAX_NUM_DESC=8.
  - typedef dma_desc_idx_t.
- s_dma_desc_t is reused unchanged.
- No sub-module; the watchdog is inline logic.

Test Plan:
- Two descriptors, both enabled, 256 B each; rd_done 5 cycles after valid, wr_done 8 cycles after; pend drops 2 cycles later -> exactly two valid pulse pairs; dma_desc_idx_o 0 then 1; one dma_done_o; error=0, abort=0.
- Slot0 disabled, slot1 num_bytes=0 -> no valid pulses; dma_done_o 4 cycles after go (CFG x3, DONE).
- Same-cycle rd_done and wr_done for slot0, with pend=0 -> DRAIN for 1 cycle, CFG the next cycle, slot1 valids 2 cycles later.
- dma_abort_i pulse mid-RUN of slot0 -> slot1 never started; done pulse after drain; dma_abort_o=1; new go clears it.
- dma_axi_err_i pulse in RUN -> dma_error_o=1 held through IDLE; cleared on next go.
- Watchdog macro defined, DMA_WDOG_CYCLES=16, streamer done never arrives -> dma_error_o=1 and dma_done_o 16 cycles after valid.
